// File: rtl/scan_pkg.sv
// Shared constants, default parameters and helpers for the section scan engine.
package scan_pkg;

    localparam int NUM_SECTIONS     = 8;
    localparam int SEC_DATA_W       = 3;
    localparam int IDX_W            = $clog2(NUM_SECTIONS);

    localparam int SCAN_DIV_DEF     = 50000;
    localparam int DEB_CYCLES_DEF   = 250000;
    localparam int BLANK_CYCLES_DEF = 8;

    typedef logic [NUM_SECTIONS-1:0] sec_mask_t;
    typedef logic [SEC_DATA_W-1:0]   sec_data_t;
    typedef logic [IDX_W-1:0]        sec_idx_t;

    function automatic sec_mask_t idx_to_onehot(input sec_idx_t idx);
        sec_mask_t mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounced button: toggles its state after DEB_CYCLES consecutive
// cycles of a (pre-synchronized) input that disagrees with the current state.
module debounce_cell
    import scan_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic state
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Any agreement with the current state restarts the count, so bounces never accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (din == state) begin
            cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ~state;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/section_scan_engine.sv
// Time-multiplexed section scanner with per-slot switch sampling and
// button debouncing. Define SCAN_BLANKING_EN to blank the start of each slot.
module section_scan_engine
    import scan_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_SECTIONS-1:0] interruptors,
    input  logic [SEC_DATA_W-1:0]   data_section0,
    input  logic [SEC_DATA_W-1:0]   data_section1,
    input  logic [SEC_DATA_W-1:0]   data_section2,
    input  logic [SEC_DATA_W-1:0]   data_section3,
    input  logic [SEC_DATA_W-1:0]   data_section4,
    input  logic [SEC_DATA_W-1:0]   data_section5,
    input  logic [SEC_DATA_W-1:0]   data_section6,
    input  logic [SEC_DATA_W-1:0]   data_section7,
    input  logic                    data_switch,
    output logic [NUM_SECTIONS-1:0] selector,
    output logic [SEC_DATA_W-1:0]   data_output,
    output logic [NUM_SECTIONS-1:0] state_switch,
    output logic [NUM_SECTIONS-1:0] state_buttons
);

    localparam int                 PRESC_W    = $clog2(SCAN_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYCLES);
`ifdef SCAN_BLANKING_EN
    localparam bit                 BLANK_EN   = 1'b1;
`else
    localparam bit                 BLANK_EN   = 1'b0;
`endif

    sec_data_t sections [NUM_SECTIONS];
    assign sections[0] = data_section0;
    assign sections[1] = data_section1;
    assign sections[2] = data_section2;
    assign sections[3] = data_section3;
    assign sections[4] = data_section4;
    assign sections[5] = data_section5;
    assign sections[6] = data_section6;
    assign sections[7] = data_section7;

    // Two-flop synchronizers for the asynchronous inputs.
    sec_mask_t btn_meta, btn_sync;
    logic      sw_meta, sw_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= 1'b0;
            sw_sync  <= 1'b0;
        end else begin
            btn_meta <= interruptors;
            btn_sync <= btn_meta;
            sw_meta  <= data_switch;
            sw_sync  <= sw_meta;
        end
    end

    // running distinguishes the first enabled edge, which opens slot 0 at prescaler 0.
    logic               running;
    sec_idx_t           idx, idx_next;
    logic [PRESC_W-1:0] presc, presc_next;
    logic               slot_end;
    logic               blank;

    always_comb begin
        idx_next   = '0;
        presc_next = '0;
        slot_end   = enable && running && (presc == PRESC_LAST);
        if (enable && running) begin
            if (presc == PRESC_LAST) begin
                idx_next = idx + IDX_W'(1);
            end else begin
                idx_next   = idx;
                presc_next = presc + PRESC_W'(1);
            end
        end
        blank = BLANK_EN && (presc_next < BLANK_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running      <= 1'b0;
            idx          <= '0;
            presc        <= '0;
            selector     <= '0;
            data_output  <= '0;
            state_switch <= '0;
        end else if (!enable) begin
            running      <= 1'b0;
            idx          <= '0;
            presc        <= '0;
            selector     <= '0;
            data_output  <= '0;
        end else begin
            running      <= 1'b1;
            idx          <= idx_next;
            presc        <= presc_next;
            selector     <= blank ? '0 : idx_to_onehot(idx_next);
            data_output  <= blank ? '0 : sections[idx_next];
            if (slot_end)
                state_switch[idx] <= sw_sync;
        end
    end

    for (genvar i = 0; i < NUM_SECTIONS; i++) begin : g_deb
        debounce_cell #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .din   (btn_sync[i]),
            .state (state_buttons[i])
        );
    end

endmodule

// File: doc/section_scan_engine.md
Name: section_scan_engine

Overview:
- Core engine beneath the Wishbone buttons/LED/visualization peripheral.
- Consumes the eight 3-bit section registers and the enable bit written over the bus.
- Drives the time-multiplexed display:
  - one-hot section selector;
  - 3-bit section data;
  - samples the shared switch return line per section into a status byte.
- Independently debounces the eight front-panel interruptors into a stable button-state byte that the bus wrapper reads back.

Parameters:
- SCAN_DIV, 50000: clock cycles per section slot; legal range is 4 or more.
- DEB_CYCLES, 250000: consecutive stable cycles required before a debounced button changes state; legal range is 2 or more.
- BLANK_CYCLES, 8: dead-time cycles at slot start. Used only with SCAN_BLANKING_EN. Must be less than SCAN_DIV-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  scan enable from the bus register
- interruptors  in  8  raw asynchronous push-buttons
- data_section0 .. data_section7  in  3 each  per-section display data from the bus registers
- data_switch  in  1  asynchronous shared switch return line
- selector  out  8  one-hot section select, all zero when idle
- data_output  out  3  data for the currently selected section
- state_switch  out  8  latched switch state per section
- state_buttons  out  8  debounced interruptor state

Behaviour:
- Reset values: every output is 0; scan index 0; prescaler 0; all debounce counters 0.
- Reset has priority over everything, including mid-slot and mid-debounce operation.
- Synchronisation: interruptors and data_switch each pass through a 2-flop synchronizer. All logic below uses the synchronized copies.
- Scan state: a 3-bit index (0..7) and a prescaler (0..SCAN_DIV-1).
  - With enable=1, the prescaler increments every cycle.
  - At SCAN_DIV-1 the prescaler returns to 0 and the index increments; the index wraps from 7 to 0.
  - The first clock edge with enable=1 (from idle) starts slot 0 with prescaler 0.
- Outputs (registered): while enable=1, selector = 1 shifted left by index and data_output = data_sectionN, where N is the index.
  - data_output is refreshed every cycle, so a bus write to the current section is visible one cycle later.
- Disable: with enable=0 at an edge, index, prescaler, selector and data_output all go to 0 on that edge. state_switch holds its value.
  - Re-enable always restarts at section 0 with a full slot.
- Switch sampling: in the cycle where the prescaler equals SCAN_DIV-1 and enable=1, the synchronized data_switch is written to state_switch bit N (N = index). All other bits hold.
  - The sample is taken only at the end of a slot; glitches earlier in the slot are ignored.
- Debounce (per button, independent of enable):
  - If the synchronized input equals state_buttons bit i, that button's counter clears.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1, bit i toggles on that edge and the counter clears.
  - Minimum latency from a raw edge to the output change is 2 + DEB_CYCLES cycles.
  - Any bounce back to the current state restarts the count.
- Debounce counter width is clog2(DEB_CYCLES); prescaler width is clog2(SCAN_DIV). Neither counter may wrap past its terminal value.

Optional Feature:
- Macro: SCAN_BLANKING_EN.
- Defined: while the prescaler is below BLANK_CYCLES, selector and data_output are forced to 0 to suppress ghosting between sections. Sampling still occurs at SCAN_DIV-1.
- Undefined: the selector is active for the whole slot, and BLANK_CYCLES is ignored.

Decomposition:
- Package scan_pkg holds:
  - NUM_SECTIONS = 8;
  - SEC_DATA_W = 3;
  - default values for SCAN_DIV, DEB_CYCLES and BLANK_CYCLES;
  - a helper function that converts an index to a one-hot value.
- Sub-module debounce_cell: one synchronized input, its counter and its state bit, with DEB_CYCLES as a parameter. It is instantiated 8 times via generate.
- The scan logic stays in the top module.

Test Plan (SCAN_DIV=8, DEB_CYCLES=4, BLANK_CYCLES=2):
- Reset asserted for 3 cycles -> all outputs 0. Released with enable=0 -> outputs remain 0.
- Set data_sectionK=K, then raise enable -> selector=0x01 and data_output=0 for 8 cycles, then 0x02/1, ... 0x80/7. Cycle 64 wraps to 0x01/0.
- Drive data_switch=1 only during slot 3 -> state_switch=0x08 after the slot 3 end cycle. A 1-cycle pulse mid-slot 5 leaves state_switch unchanged.
- interruptors[0]=1 for 3 cycles, then 0 -> state_buttons stays 0x00. Held at 1 -> state_buttons=0x01 after 6 cycles. Release -> 0x00 after 6 more cycles.
- Drop enable mid-slot 5 -> selector=0 and data_output=0 on the next edge. Re-enable -> 0x01 with a full 8-cycle slot. Assert reset mid-slot -> full reset state.
- With SCAN_BLANKING_EN: each slot shows selector=0 for 2 cycles, then one-hot for 6 cycles.
